// File: rtl/rx_data_path.sv
// UART receive data path: shift register, frame remap by format, and sticky status flags.
// Sequencing (btu/start/done) comes from the separate receive control block.
module rx_data_path (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       btu,
  input  logic       start,
  input  logic       done,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       read_rx,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  logic [9:0] sr;
  logic [7:0] data_remap;
  logic       par_bit;
  logic       stop_bit;
  logic       par_err;
  logic       frame_err;

  // Bits enter at the top, so a short frame leaves its first data bit higher up in sr.
  always_comb begin
    data_remap = 8'h00;
    par_bit    = 1'b0;
    case ({eight, pen})
      2'b11: begin
        data_remap = sr[7:0];
        par_bit    = sr[8];
      end
      2'b10: data_remap = sr[8:1];
      2'b01: begin
        data_remap = {1'b0, sr[7:1]};
        par_bit    = sr[8];
      end
      default: data_remap = {1'b0, sr[8:2]};
    endcase
  end

  assign stop_bit  = sr[9];
  assign par_err   = pen & (par_bit ^ (^data_remap) ^ ohel);
  assign frame_err = ~stop_bit;

  // The start-bit centre btu arrives with start=1 and must not shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= 10'd0;
    end else if (done) begin
      sr <= 10'd0;
    end else if (btu && !start) begin
      sr <= {rx, sr[9:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data <= 8'h00;
    end else if (done) begin
      rx_data <= data_remap;
    end
  end

  // A read coincident with done clears the old flags before the new frame's flags apply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end else if (done) begin
      rxrdy <= 1'b1;
      perr  <= (perr & ~read_rx) | par_err;
      ferr  <= (ferr & ~read_rx) | frame_err;
      ovf   <= (ovf | rxrdy) & ~read_rx;
    end else if (read_rx) begin
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_data_path.sv
// Testbench for rx_data_path: directed frame scenarios plus randomized frames
// checked against a frame-level model of the received character and status flags.
module tb_rx_data_path;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       btu = 1'b0;
  logic       start = 1'b0;
  logic       done = 1'b0;
  logic       eight = 1'b1;
  logic       pen = 1'b0;
  logic       ohel = 1'b0;
  logic       read_rx = 1'b0;
  logic [7:0] rx_data;
  logic       rxrdy;
  logic       perr;
  logic       ferr;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of what the host should see
  logic [7:0] m_data  = 8'h00;
  logic       m_rxrdy = 1'b0;
  logic       m_perr  = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_ovf   = 1'b0;

  rx_data_path dut (
    .clk(clk), .rst(rst), .rx(rx), .btu(btu), .start(start), .done(done),
    .eight(eight), .pen(pen), .ohel(ohel), .read_rx(read_rx),
    .rx_data(rx_data), .rxrdy(rxrdy), .perr(perr), .ferr(ferr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_btu(input logic b);
    rx = b;
    repeat ($urandom_range(0, 2)) tick();
    btu = 1'b1;
    tick();
    btu = 1'b0;
  endtask

  task automatic send_start;
    start = 1'b1;
    rx    = 1'b0;
    tick();
    btu = 1'b1;
    tick();
    btu = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic model_reset;
    m_data = 8'h00; m_rxrdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_read;
    m_rxrdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
  endtask

  // Shifts data (LSB first), optional parity and stop bit, then pulses done.
  task automatic send_body(input logic [7:0] d, input logic e, input logic p, input logic o,
                           input logic par_b, input logic stop_b, input logic rd);
    logic [7:0] exp_d;
    logic       good_par;
    eight = e; pen = p; ohel = o;
    for (int i = 0; i < (e ? 8 : 7); i++) pulse_btu(d[i]);
    if (p) pulse_btu(par_b);
    pulse_btu(stop_b);
    done = 1'b1;
    read_rx = rd;
    tick();
    done = 1'b0;
    read_rx = 1'b0;
    exp_d    = e ? d : (d & 8'h7F);
    good_par = (($countones(exp_d) % 2) == 1) ^ o;
    if (rd) model_read();
    m_ovf   = m_ovf | m_rxrdy;
    m_rxrdy = 1'b1;
    if (p && (par_b != good_par)) m_perr = 1'b1;
    if (!stop_b) m_ferr = 1'b1;
    m_data = exp_d;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic e, input logic p, input logic o,
                            input logic par_b, input logic stop_b, input logic rd);
    send_start();
    send_body(d, e, p, o, par_b, stop_b, rd);
  endtask

  task automatic host_read;
    read_rx = 1'b1;
    tick();
    read_rx = 1'b0;
    model_read();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({rx_data, rxrdy, perr, ferr, ovf} !== 12'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h %b%b%b%b, expected 00 0000", rx_data, rxrdy, perr, ferr, ovf);
    end
    n_checks++;
    if (dut.sr !== 10'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_sr: got %h, expected 000", dut.sr);
    end
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic test_8e1;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({rx_data, rxrdy, perr, ferr, ovf} !== {8'hA5, 4'b1000}) begin
      n_fail++;
      $display("[TB] FAIL frame_8e1: got %h %b%b%b%b, expected a5 1000", rx_data, rxrdy, perr, ferr, ovf);
    end
  endtask

  task automatic test_7o1_parity_error;
    host_read();
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({rx_data, rxrdy, perr, ferr, ovf} !== {8'h41, 4'b1100}) begin
      n_fail++;
      $display("[TB] FAIL frame_7o1_perr: got %h %b%b%b%b, expected 41 1100", rx_data, rxrdy, perr, ferr, ovf);
    end
    host_read();
    n_checks++;
    if ({rx_data, rxrdy, perr, ferr, ovf} !== {8'h41, 4'b0000}) begin
      n_fail++;
      $display("[TB] FAIL read_clears: got %h %b%b%b%b, expected 41 0000", rx_data, rxrdy, perr, ferr, ovf);
    end
  endtask

  task automatic test_framing;
    host_read();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({rx_data, rxrdy, perr, ferr, ovf} !== {8'h3C, 4'b1010}) begin
      n_fail++;
      $display("[TB] FAIL frame_ferr: got %h %b%b%b%b, expected 3c 1010", rx_data, rxrdy, perr, ferr, ovf);
    end
  endtask

  task automatic test_back_to_back;
    host_read();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({rx_data, rxrdy, perr, ferr, ovf} !== {8'h11, 4'b1000}) begin
      n_fail++;
      $display("[TB] FAIL b2b_first: got %h %b%b%b%b, expected 11 1000", rx_data, rxrdy, perr, ferr, ovf);
    end
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({rx_data, rxrdy, perr, ferr, ovf} !== {8'h22, 4'b1001}) begin
      n_fail++;
      $display("[TB] FAIL b2b_overrun: got %h %b%b%b%b, expected 22 1001", rx_data, rxrdy, perr, ferr, ovf);
    end
    host_read();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({rx_data, rxrdy, perr, ferr, ovf} !== {8'h22, 4'b1000}) begin
      n_fail++;
      $display("[TB] FAIL b2b_read_at_done: got %h %b%b%b%b, expected 22 1000", rx_data, rxrdy, perr, ferr, ovf);
    end
  endtask

  task automatic test_reset_midframe;
    eight = 1'b1; pen = 1'b0;
    send_start();
    for (int i = 0; i < 4; i++) pulse_btu(1'b1);
    rst = 1'b1;
    #2;
    n_checks++;
    if ({rx_data, rxrdy, perr, ferr, ovf} !== 12'h000) begin
      n_fail++;
      $display("[TB] FAIL async_reset_outputs: got %h %b%b%b%b, expected 00 0000", rx_data, rxrdy, perr, ferr, ovf);
    end
    n_checks++;
    if (dut.sr !== 10'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_sr: got %h, expected 000", dut.sr);
    end
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({rx_data, rxrdy, perr, ferr, ovf} !== {8'h5A, 4'b1000}) begin
      n_fail++;
      $display("[TB] FAIL after_reset_frame: got %h %b%b%b%b, expected 5a 1000", rx_data, rxrdy, perr, ferr, ovf);
    end
  endtask

  task automatic test_7n1_start;
    host_read();
    eight = 1'b0; pen = 1'b0;
    send_start();
    n_checks++;
    if (dut.sr !== 10'd0) begin
      n_fail++;
      $display("[TB] FAIL start_btu_no_shift: got sr %h, expected 000", dut.sr);
    end
    send_body(8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({rx_data, rxrdy, perr, ferr, ovf} !== {8'h7F, 4'b1000}) begin
      n_fail++;
      $display("[TB] FAIL frame_7n1: got %h %b%b%b%b, expected 7f 1000", rx_data, rxrdy, perr, ferr, ovf);
    end
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic       e, p, o, par_b, stop_b, rd;
    for (int n = 0; n < 60; n++) begin
      d  = 8'($urandom);
      e  = 1'($urandom);
      p  = 1'($urandom);
      o  = 1'($urandom);
      // Correct parity most of the time, deliberately wrong otherwise
      par_b  = 1'(($countones(e ? d : (d & 8'h7F)) % 2)) ^ o ^ ($urandom_range(0, 3) == 0);
      stop_b = ($urandom_range(0, 4) != 0);
      rd     = ($urandom_range(0, 3) == 0);
      send_frame(d, e, p, o, par_b, stop_b, rd);
      n_checks++;
      if ({rx_data, rxrdy, perr, ferr, ovf} !== {m_data, m_rxrdy, m_perr, m_ferr, m_ovf}) begin
        n_fail++;
        $display("[TB] FAIL rand_frame %0d: got %h %b%b%b%b, expected %h %b%b%b%b", n,
                 rx_data, rxrdy, perr, ferr, ovf, m_data, m_rxrdy, m_perr, m_ferr, m_ovf);
      end
      if ($urandom_range(0, 2) == 0) begin
        host_read();
        n_checks++;
        if ({rx_data, rxrdy, perr, ferr, ovf} !== {m_data, m_rxrdy, m_perr, m_ferr, m_ovf}) begin
          n_fail++;
          $display("[TB] FAIL rand_read %0d: got %h %b%b%b%b, expected %h %b%b%b%b", n,
                   rx_data, rxrdy, perr, ferr, ovf, m_data, m_rxrdy, m_perr, m_ferr, m_ovf);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_8e1();
    test_7o1_parity_error();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_7n1_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
